// File: rtl/memory_access_if.sv
// Data-memory bus between the memory stage and the data memory.
// The stage drives the request side; the memory returns read data with a one-cycle ack.
interface memory_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memory_access.sv
// Memory stage between execute and writeback: ALU pass-through, loads and stores
// over a req/ack bus with lane steering, extension, misalign check and timeout.
module memory_access #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [31:0]        data_result_in,
    input  logic [31:0]        store_data_in,
    input  logic [2:0]         funct3_in,
    input  logic               is_load_in,
    input  logic               is_store_in,
    input  logic [4:0]         reg_dest_in,
    input  logic               write_enable_in,
    output logic               stall_out,
    memory_access_if.master    bus,
    output logic [31:0]        data_result,
    output logic [4:0]         reg_dest_out,
    output logic               write_enable_out,
    output logic               valid_out,
    output logic               access_fault,
    output logic               timeout_fault
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  op_off, op_off_n;
    logic [2:0]  op_f3, op_f3_n;
    logic [4:0]  op_rd, op_rd_n;
    logic        op_we, op_we_n;

    logic        req_q, req_n;
    logic        we_q, we_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;

    logic [31:0] data_n;
    logic [4:0]  rd_n;
    logic        wen_n, valid_n, af_n, tf_n;

    logic        bad_f3, misalign, illegal;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] shifted, load_val;

    assign stall_out     = (state == WAIT);
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;

    // Classify the incoming load/store and build its store lanes
    always_comb begin
        bad_f3 = 1'b0;
        if (is_store_in) begin
            bad_f3 = !(funct3_in inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_f3 = !(funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misalign = ((funct3_in[1:0] == 2'b01) && data_result_in[0])
                || ((funct3_in[1:0] == 2'b10) && (data_result_in[1:0] != 2'b00));
        illegal  = (is_load_in && is_store_in) || bad_f3 || misalign;

        lane_wdata = store_data_in;
        lane_wstrb = 4'b1111;
        unique case (funct3_in[1:0])
            2'b00: begin
                lane_wdata = {4{store_data_in[7:0]}};
                lane_wstrb = 4'b0001 << data_result_in[1:0];
            end
            2'b01: begin
                lane_wdata = {2{store_data_in[15:0]}};
                lane_wstrb = 4'b0011 << {data_result_in[1], 1'b0};
            end
            default: begin
                lane_wdata = store_data_in;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    // Align returned read data to bit 0 and extend it by the latched size/sign
    always_comb begin
        shifted  = bus.mem_rdata >> {op_off, 3'b000};
        load_val = shifted;
        unique case (op_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state and next-output decision for the IDLE/WAIT controller
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_off_n = op_off;
        op_f3_n  = op_f3;
        op_rd_n  = op_rd;
        op_we_n  = op_we;
        req_n    = req_q;
        we_n     = we_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        wstrb_n  = wstrb_q;
        data_n   = data_result;
        rd_n     = reg_dest_out;
        wen_n    = 1'b0;
        valid_n  = 1'b0;
        af_n     = 1'b0;
        tf_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (valid_in) begin
                    if (!is_load_in && !is_store_in) begin
                        data_n  = data_result_in;
                        rd_n    = reg_dest_in;
                        wen_n   = write_enable_in;
                        valid_n = 1'b1;
                    end else if (illegal) begin
                        af_n    = 1'b1;
                        valid_n = 1'b1;
                    end else begin
                        state_n  = WAIT;
                        cnt_n    = 8'd0;
                        req_n    = 1'b1;
                        we_n     = is_store_in;
                        addr_n   = {data_result_in[31:2], 2'b00};
                        wdata_n  = is_store_in ? lane_wdata : 32'h0;
                        wstrb_n  = is_store_in ? lane_wstrb : 4'b0000;
                        op_off_n = data_result_in[1:0];
                        op_f3_n  = funct3_in;
                        op_rd_n  = reg_dest_in;
                        op_we_n  = write_enable_in && is_load_in;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    rd_n    = op_rd;
                    if (!we_q) begin
                        data_n = load_val;
                        wen_n  = op_we;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    tf_n    = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, bus and writeback registers; reset abandons any pending access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            op_off           <= 2'b00;
            op_f3            <= 3'b000;
            op_rd            <= 5'd0;
            op_we            <= 1'b0;
            req_q            <= 1'b0;
            we_q             <= 1'b0;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            wstrb_q          <= 4'b0000;
            data_result      <= 32'h0;
            reg_dest_out     <= 5'd0;
            write_enable_out <= 1'b0;
            valid_out        <= 1'b0;
            access_fault     <= 1'b0;
            timeout_fault    <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            op_off           <= op_off_n;
            op_f3            <= op_f3_n;
            op_rd            <= op_rd_n;
            op_we            <= op_we_n;
            req_q            <= req_n;
            we_q             <= we_n;
            addr_q           <= addr_n;
            wdata_q          <= wdata_n;
            wstrb_q          <= wstrb_n;
            data_result      <= data_n;
            reg_dest_out     <= rd_n;
            write_enable_out <= wen_n;
            valid_out        <= valid_n;
            access_fault     <= af_n;
            timeout_fault    <= tf_n;
        end
    end

endmodule
